// File: rtl/pipe_reg_gen.sv
// Generic inter-stage pipeline register for the five-stage MIPS core.
// It handles req/flush/en priority, earliest-wins exception merging and saturating stall/bubble counters.
module pipe_reg_gen #(
  parameter int              PC_W    = 32,
  parameter int              INSTR_W = 32,
  parameter int              EXT_W   = 32,
  parameter int              EXC_W   = 5,
  parameter logic [PC_W-1:0] REQ_PC  = PC_W'(32'h0000_4180),
  parameter int              CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req,
  input  logic               flush,
  input  logic               en,
  input  logic               clr_cnt,
  input  logic               in_valid,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [EXT_W-1:0]   in_ext,
  input  logic               in_bd,
  input  logic               in_exc_err,
  input  logic [EXC_W-1:0]   in_exc_code,
  input  logic               stage_exc_err,
  input  logic [EXC_W-1:0]   stage_exc_code,
  output logic               out_valid,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [EXT_W-1:0]   out_ext,
  output logic               out_bd,
  output logic               out_exc_err,
  output logic [EXC_W-1:0]   out_exc_code,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  // An exception carried in from upstream is older than one raised here, so it wins.
  function automatic logic [EXC_W-1:0] merge_code(input logic up_err,
                                                  input logic [EXC_W-1:0] up_code,
                                                  input logic st_err,
                                                  input logic [EXC_W-1:0] st_code);
    if (up_err)      return up_code;
    else if (st_err) return st_code;
    else             return '0;
  endfunction

  logic               vld_p1;
  logic [PC_W-1:0]    pc_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic [EXT_W-1:0]   ext_p1;
  logic               bd_p1;
  logic               exc_err_p1;
  logic [EXC_W-1:0]   exc_code_p1;
  logic [CNT_W-1:0]   stall_cnt_p1;
  logic [CNT_W-1:0]   bubble_cnt_p1;

  logic hold_p0;
  logic bubble_p0;

  assign hold_p0   = !req && !flush && !en;
  assign bubble_p0 = !req && (flush || (en && !in_valid));

  // p0 -> p1: stage register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1      <= 1'b0;
      pc_p1       <= '0;
      instr_p1    <= '0;
      ext_p1      <= '0;
      bd_p1       <= 1'b0;
      exc_err_p1  <= 1'b0;
      exc_code_p1 <= '0;
    end else if (req) begin
      vld_p1      <= 1'b0;
      pc_p1       <= REQ_PC;
      instr_p1    <= '0;
      ext_p1      <= '0;
      bd_p1       <= 1'b0;
      exc_err_p1  <= 1'b0;
      exc_code_p1 <= '0;
    end else if (flush || en) begin
      // PC and BD survive into bubbles so the macro-PC stays meaningful.
      pc_p1       <= in_pc;
      bd_p1       <= in_bd;
      if (!flush && in_valid) begin
        vld_p1      <= 1'b1;
        instr_p1    <= in_instr;
        ext_p1      <= in_ext;
        exc_err_p1  <= in_exc_err | stage_exc_err;
        exc_code_p1 <= merge_code(in_exc_err, in_exc_code, stage_exc_err, stage_exc_code);
      end else begin
        vld_p1      <= 1'b0;
        instr_p1    <= '0;
        ext_p1      <= '0;
        exc_err_p1  <= 1'b0;
        exc_code_p1 <= '0;
      end
    end
  end

  // p0 -> p1: performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
    end else if (clr_cnt) begin
      stall_cnt_p1  <= '0;
      bubble_cnt_p1 <= '0;
    end else begin
      if (hold_p0 && vld_p1) stall_cnt_p1  <= sat_inc(stall_cnt_p1);
      if (bubble_p0)         bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign out_valid    = vld_p1;
  assign out_pc       = pc_p1;
  assign out_instr    = instr_p1;
  assign out_ext      = ext_p1;
  assign out_bd       = bd_p1;
  assign out_exc_err  = exc_err_p1;
  assign out_exc_code = exc_code_p1;
  assign stall_cnt    = stall_cnt_p1;
  assign bubble_cnt   = bubble_cnt_p1;

endmodule

// File: tb/tb_pipe_reg_gen.sv
// Bench for pipe_reg_gen: directed steps with a scoreboard of expected register contents.
module tb_pipe_reg_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, flush, en, clr_cnt, in_valid, in_bd, in_exc_err, stage_exc_err;
  logic [31:0] in_pc, in_instr, in_ext;
  logic [4:0]  in_exc_code, stage_exc_code;
  logic        out_valid, out_bd, out_exc_err;
  logic [31:0] out_pc, out_instr, out_ext;
  logic [4:0]  out_exc_code;
  logic [3:0]  stall_cnt, bubble_cnt;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ext;
    logic        bd;
    logic        ee;
    logic [4:0]  ec;
    logic [3:0]  sc;
    logic [3:0]  bc;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  pipe_reg_gen #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .flush(flush), .en(en), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ext(in_ext), .in_bd(in_bd),
    .in_exc_err(in_exc_err), .in_exc_code(in_exc_code),
    .stage_exc_err(stage_exc_err), .stage_exc_code(stage_exc_code),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ext(out_ext),
    .out_bd(out_bd), .out_exc_err(out_exc_err), .out_exc_code(out_exc_code),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".valid"},  32'(out_valid),    32'(e.v));
    chk({tag, ".pc"},     out_pc,            e.pc);
    chk({tag, ".instr"},  out_instr,         e.instr);
    chk({tag, ".ext"},    out_ext,           e.ext);
    chk({tag, ".bd"},     32'(out_bd),       32'(e.bd));
    chk({tag, ".exc"},    32'(out_exc_err),  32'(e.ee));
    chk({tag, ".code"},   32'(out_exc_code), 32'(e.ec));
    chk({tag, ".stall"},  32'(stall_cnt),    32'(e.sc));
    chk({tag, ".bubble"}, 32'(bubble_cnt),   32'(e.bc));
  endtask

  // Reference behaviour of one posedge, derived from the register's priority rules.
  function automatic exp_t model_next(input exp_t s);
    exp_t n = s;
    logic hold_c = !req && !flush && !en;
    logic bub_c  = !req && (flush || (en && !in_valid));
    if (req) begin
      n.v = 0; n.pc = 32'h0000_4180; n.instr = 0; n.ext = 0; n.bd = 0; n.ee = 0; n.ec = 0;
    end else if (flush) begin
      n.v = 0; n.pc = in_pc; n.instr = 0; n.ext = 0; n.bd = in_bd; n.ee = 0; n.ec = 0;
    end else if (en) begin
      n.pc = in_pc; n.bd = in_bd;
      if (in_valid) begin
        n.v = 1; n.instr = in_instr; n.ext = in_ext;
        n.ee = in_exc_err | stage_exc_err;
        n.ec = in_exc_err ? in_exc_code : (stage_exc_err ? stage_exc_code : 5'd0);
      end else begin
        n.v = 0; n.instr = 0; n.ext = 0; n.ee = 0; n.ec = 0;
      end
    end
    if (clr_cnt) begin
      n.sc = 0; n.bc = 0;
    end else begin
      if (hold_c && s.v && s.sc != 4'hF) n.sc = s.sc + 4'd1;
      if (bub_c && s.bc != 4'hF)         n.bc = s.bc + 4'd1;
    end
    return n;
  endfunction

  task automatic step(input string tag);
    exp_t e;
    m = model_next(m);
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk_all(tag, e);
    end
  endtask

  task automatic ctl(input logic r, input logic f, input logic e, input logic v, input logic c);
    req = r; flush = f; en = e; in_valid = v; clr_cnt = c;
  endtask

  task automatic exc(input logic ie, input logic [4:0] ic, input logic se, input logic [4:0] sc);
    in_exc_err = ie; in_exc_code = ic; stage_exc_err = se; stage_exc_code = sc;
  endtask

  initial begin
    reset_n = 0;
    {req, flush, en, clr_cnt, in_valid, in_bd, in_exc_err, stage_exc_err} = 8'($urandom);
    in_pc = $urandom; in_instr = $urandom; in_ext = $urandom;
    in_exc_code = 5'($urandom); stage_exc_code = 5'($urandom);
    m = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", m);

    @(negedge clk);
    reset_n = 1;
    ctl(0, 0, 1, 1, 0); exc(0, 0, 0, 0);
    in_pc = 32'h3000; in_instr = 32'h2401_0001; in_ext = 32'h1111_2222; in_bd = 0;
    step("load0");
    chk("load0_pc", out_pc, 32'h3000);
    chk("load0_instr", out_instr, 32'h2401_0001);

    in_pc = 32'h3004; in_instr = 32'h2402_0002;
    step("load1");
    ctl(0, 0, 0, 1, 0); in_pc = 32'h3008; in_instr = 32'h2403_0003;
    step("stall1"); step("stall2"); step("stall3");
    chk("stall_pc", out_pc, 32'h3004);
    chk("stall_cnt3", 32'(stall_cnt), 32'd3);
    ctl(0, 0, 1, 1, 0);
    step("advance");
    chk("advance_pc", out_pc, 32'h3008);

    ctl(1, 1, 1, 1, 0); in_pc = 32'h3010;
    step("req_all");
    chk("req_pc", out_pc, 32'h4180);
    chk("req_bubble", 32'(bubble_cnt), 32'd0);
    ctl(0, 1, 0, 1, 0); in_pc = 32'h3014; in_bd = 1;
    step("flush");
    chk("flush_pc", out_pc, 32'h3014);
    chk("flush_bubble", 32'(bubble_cnt), 32'd1);

    ctl(0, 0, 1, 1, 0); in_bd = 0; in_pc = 32'h3018; exc(1, 5'd4, 1, 5'd10);
    step("exc_up");
    chk("exc_up_code", 32'(out_exc_code), 32'd4);
    in_pc = 32'h301c; exc(0, 5'd0, 1, 5'd12);
    step("exc_stage");
    chk("exc_stage_code", 32'(out_exc_code), 32'd12);
    ctl(0, 0, 1, 0, 0); in_pc = 32'h3020;
    step("exc_novalid");
    chk("exc_novalid_err", 32'(out_exc_err), 32'd0);

    for (int i = 0; i < 40; i++) begin
      req = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 4) == 0);
      en = $urandom_range(0, 1) == 1;
      clr_cnt = ($urandom_range(0, 15) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_pc = $urandom; in_instr = $urandom; in_ext = $urandom; in_bd = 1'($urandom);
      exc(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
      step("rand");
    end

    ctl(0, 0, 1, 1, 1); exc(0, 0, 0, 0); in_pc = 32'h3100;
    step("sat_load");
    ctl(0, 0, 0, 1, 0);
    repeat (20) step("sat_hold");
    chk("sat_stall", 32'(stall_cnt), 32'd15);
    clr_cnt = 1;
    step("clr");
    chk("clr_zero", 32'(stall_cnt), 32'd0);
    clr_cnt = 0;
    step("after_clr");
    chk("after_clr_one", 32'(stall_cnt), 32'd1);

    step("pre_reset");
    #2;
    reset_n = 0;
    m = '0;
    #1;
    chk_all("async_reset", m);
    chk("async_reset_pc", out_pc, 32'h0);
    @(negedge clk);
    reset_n = 1;
    ctl(0, 0, 1, 1, 0); in_pc = 32'h3200;
    step("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
